// File: rtl/mr_chk_pkg.sv
// mr_chk_pkg: shared types and widths for the waypoint run monitor
// Holds the checker state enum, the fail_code enum and the pose widths.
package mr_chk_pkg;
   localparam int XW = 15;
   localparam int HW = 12;
   localparam logic [7:0] ACK_BYTE = 8'hA5;
   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_CAL, S_WAIT_ACK, S_RUN, S_WAIT_SOL, S_PASS, S_FAIL
   } state_e;
   typedef enum logic [2:0] {
      FC_NONE, FC_CAL_TO, FC_ACK_TO, FC_BAD_ACK, FC_X, FC_Y, FC_HDG, FC_SEQ
   } fail_code_e;
endpackage

// File: rtl/tol_win_cmp.sv
// tol_win_cmp: flags when |act - tgt| exceeds a fixed tolerance
// Ports: act/tgt W-bit operands; over = 1 when the magnitude exceeds TOL.
// WRAP=1 treats the difference modulo 2^W as signed (heading);
// WRAP=0 takes the true difference of two unsigned values (position).
module tol_win_cmp #(
   parameter int W = 15,
   parameter bit WRAP = 1'b0,
   parameter logic [W-1:0] TOL = '0
) (
   input  logic [W-1:0] act,
   input  logic [W-1:0] tgt,
   output logic         over
);
   logic [W-1:0] dw;
   logic [W:0]   d;
   logic [W:0]   mag;
   // One extra bit keeps the magnitude of the most negative value (e.g. 2048 for heading).
   always_comb begin
      dw   = act - tgt;
      d    = WRAP ? {dw[W-1], dw} : ({1'b0, act} - {1'b0, tgt});
      mag  = d[W] ? -d : d;
      over = mag > {1'b0, TOL};
   end
endmodule

// File: rtl/mv_waypoint_checker.sv
// mv_waypoint_checker: pass/fail monitor for a full MazeRunner solve
// Inputs: start/wp_cnt begin a run; wp_we/wp_addr/wp_x/wp_y/wp_hdg load the table when idle;
//         cal_done, resp_rdy/resp, mv_cmplt, sol_cmplt are level events; xx/yy/hdg is the pose.
// Outputs: busy while a run is live; sticky pass/fail with fail_code and fail_idx; moves checked.
module mv_waypoint_checker
   import mr_chk_pkg::*;
#(
   parameter int N_WP = 16,
   parameter logic [XW-1:0] XY_TOL = 15'h0150,
   parameter logic [HW-1:0] HDG_TOL = 12'h050,
   parameter int CAL_TO = 1_500_000,
   parameter int ACK_TO = 1_500_000,
   parameter int MV_TO = 50_000_000,
   localparam int AW = $clog2(N_WP)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW:0]   wp_cnt,
   input  logic          wp_we,
   input  logic [AW-1:0] wp_addr,
   input  logic [XW-1:0] wp_x,
   input  logic [XW-1:0] wp_y,
   input  logic [HW-1:0] wp_hdg,
   input  logic          cal_done,
   input  logic          resp_rdy,
   input  logic          mv_cmplt,
   input  logic          sol_cmplt,
   input  logic [7:0]    resp,
   input  logic [XW-1:0] xx,
   input  logic [XW-1:0] yy,
   input  logic [HW-1:0] hdg,
   output logic          busy,
   output logic          pass,
   output logic          fail,
   output logic [2:0]    fail_code,
   output logic [AW:0]   fail_idx,
   output logic [AW:0]   moves
);
   localparam int CW = AW + 1;
   localparam int MAX_TO = (CAL_TO > ACK_TO) ? ((CAL_TO > MV_TO) ? CAL_TO : MV_TO)
                                             : ((ACK_TO > MV_TO) ? ACK_TO : MV_TO);
   localparam int TW = $clog2(MAX_TO + 1);
   localparam logic [TW-1:0] CAL_LIM = TW'(CAL_TO - 1);
   localparam logic [TW-1:0] ACK_LIM = TW'(ACK_TO - 1);
   localparam logic [TW-1:0] MV_LIM  = TW'(MV_TO - 1);

   logic [XW-1:0] tx_m [N_WP];
   logic [XW-1:0] ty_m [N_WP];
   logic [HW-1:0] th_m [N_WP];

   state_e        state_q, state_d;
   fail_code_e    code_q, code_d, fc;
   logic [TW-1:0] timer_q, timer_d;
   logic [CW-1:0] moves_q, moves_d, cnt_q, cnt_d, idx_q, idx_d, moves_inc;
   logic [3:0]    hist_q, hist_d, ins, rise;
   logic          pass_q, pass_d, fail_q, fail_d;
   logic          x_bad, y_bad, h_bad;
   logic [AW-1:0] widx;

   assign busy = (state_q == S_WAIT_CAL) || (state_q == S_WAIT_ACK) ||
                 (state_q == S_RUN) || (state_q == S_WAIT_SOL);
   assign ins  = {cal_done, resp_rdy, mv_cmplt, sol_cmplt};
   assign rise = ins & ~hist_q;
   assign widx = moves_q[AW-1:0];
   assign moves_inc = moves_q + CW'(1);

   // No reset on the table so a loaded route survives rst.
   always_ff @(posedge clk)
      if (wp_we && !busy) begin
         tx_m[wp_addr] <= wp_x;
         ty_m[wp_addr] <= wp_y;
         th_m[wp_addr] <= wp_hdg;
      end

   tol_win_cmp #(.W(XW), .WRAP(1'b0), .TOL(XY_TOL))  u_x (.act(xx),  .tgt(tx_m[widx]), .over(x_bad));
   tol_win_cmp #(.W(XW), .WRAP(1'b0), .TOL(XY_TOL))  u_y (.act(yy),  .tgt(ty_m[widx]), .over(y_bad));
   tol_win_cmp #(.W(HW), .WRAP(1'b1), .TOL(HDG_TOL)) u_h (.act(hdg), .tgt(th_m[widx]), .over(h_bad));

   always_comb begin
      state_d = state_q;
      timer_d = busy ? timer_q + TW'(1) : '0;
      moves_d = moves_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      code_d  = code_q;
      idx_d   = idx_q;
      hist_d  = ins;
      fc      = FC_NONE;
      case (state_q)
         S_WAIT_CAL:
            if (rise[3]) state_d = S_WAIT_ACK;
            else if (timer_q == CAL_LIM) fc = FC_CAL_TO;
         S_WAIT_ACK:
            if (rise[2]) begin
               if (resp == ACK_BYTE) state_d = (cnt_q == '0) ? S_WAIT_SOL : S_RUN;
               else fc = FC_BAD_ACK;
            end else if (timer_q == ACK_LIM) fc = FC_ACK_TO;
         S_RUN:
            if (rise[1]) begin
               fc = x_bad ? FC_X : y_bad ? FC_Y : h_bad ? FC_HDG : FC_NONE;
               if (fc == FC_NONE) begin
                  moves_d = moves_inc;
                  timer_d = '0;
                  // A solve flagged together with the last good move is a legal finish.
                  if (moves_inc == cnt_q) state_d = rise[0] ? S_PASS : S_WAIT_SOL;
                  else if (rise[0]) fc = FC_SEQ;
               end
            end else if (rise[0] || timer_q == MV_LIM) fc = FC_SEQ;
         S_WAIT_SOL:
            if (rise[0]) state_d = S_PASS;
            else if (rise[1] || timer_q == MV_LIM) fc = FC_SEQ;
         default:
            if (start) begin
               state_d = S_WAIT_CAL;
               cnt_d   = wp_cnt;
               moves_d = '0;
               pass_d  = 1'b0;
               fail_d  = 1'b0;
               code_d  = FC_NONE;
               idx_d   = '0;
            end
      endcase
      if (fc != FC_NONE) begin
         state_d = S_FAIL;
         moves_d = moves_q;
         fail_d  = 1'b1;
         code_d  = fc;
         idx_d   = moves_q;
      end
      if (state_d == S_PASS && state_q != S_PASS) pass_d = 1'b1;
      if (state_d != state_q) timer_d = '0;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         moves_q <= '0;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         code_q  <= FC_NONE;
         idx_q   <= '0;
         hist_q  <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         moves_q <= moves_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         code_q  <= code_d;
         idx_q   <= idx_d;
         hist_q  <= hist_d;
      end

   assign pass      = pass_q;
   assign fail      = fail_q;
   assign fail_code = code_q;
   assign fail_idx  = idx_q;
   assign moves     = moves_q;
endmodule
